// File: rtl/multiplier_datapath.sv
// Shift-and-add datapath for the sequential multiplier: one partial product per clock, fixed WORD_LENGTH-cycle latency.
// Optional two's-complement operand support is enabled by defining SIGNED_MULT_EN.
module multiplier_datapath #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       force_reset,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       counter_flag,
    output logic                       busy
);

    localparam int W  = WORD_LENGTH;
    localparam int PW = 2 * WORD_LENGTH;
    localparam int CW = $clog2(WORD_LENGTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        LOAD,
        RUN,
        DONE
    } state_t;

    state_t          state_r, state_nxt;
    logic [PW-1:0]   mcand_r, mcand_nxt;
    logic [PW-1:0]   acc_r, acc_nxt;
    logic [PW-1:0]   acc_sum, final_val, product_nxt;
    logic [W-1:0]    mplier_r, mplier_nxt;
    logic [W-1:0]    op_a, op_b;
    logic [CW-1:0]   cnt_r, cnt_nxt;
    logic            flag_nxt, busy_nxt;

    assign acc_sum = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

`ifdef SIGNED_MULT_EN
    logic sign_r, sign_nxt;

    // Magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    assign op_a      = multiplicand[W-1] ? -multiplicand : multiplicand;
    assign op_b      = multiplier[W-1]   ? -multiplier   : multiplier;
    assign final_val = sign_r ? -acc_sum : acc_sum;
`else
    assign op_a      = multiplicand;
    assign op_b      = multiplier;
    assign final_val = acc_sum;
`endif

    always_comb begin
        state_nxt   = state_r;
        mcand_nxt   = mcand_r;
        mplier_nxt  = mplier_r;
        acc_nxt     = acc_r;
        cnt_nxt     = cnt_r;
        flag_nxt    = counter_flag;
        busy_nxt    = busy;
        product_nxt = product;
`ifdef SIGNED_MULT_EN
        sign_nxt    = sign_r;
`endif
        if (force_reset) begin
            state_nxt  = LOAD;
            mcand_nxt  = {{W{1'b0}}, op_a};
            mplier_nxt = op_b;
            acc_nxt    = '0;
            cnt_nxt    = '0;
            flag_nxt   = 1'b0;
            busy_nxt   = 1'b0;
`ifdef SIGNED_MULT_EN
            sign_nxt   = multiplicand[W-1] ^ multiplier[W-1];
`endif
        end else begin
            case (state_r)
                LOAD, RUN: begin
                    // LOAD performs the first iteration on the same edge it moves to RUN.
                    acc_nxt    = acc_sum;
                    mcand_nxt  = mcand_r << 1;
                    mplier_nxt = mplier_r >> 1;
                    cnt_nxt    = cnt_r + CW'(1);
                    if (cnt_r == LAST) begin
                        state_nxt   = DONE;
                        flag_nxt    = 1'b1;
                        busy_nxt    = 1'b0;
                        product_nxt = final_val;
                    end else begin
                        state_nxt = RUN;
                        busy_nxt  = 1'b1;
                    end
                end
                DONE: begin
                    state_nxt = DONE;
                end
                default: begin
                    state_nxt = LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= LOAD;
            mcand_r      <= '0;
            mplier_r     <= '0;
            acc_r        <= '0;
            cnt_r        <= '0;
            product      <= '0;
            counter_flag <= 1'b0;
            busy         <= 1'b0;
`ifdef SIGNED_MULT_EN
            sign_r       <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt;
            mcand_r      <= mcand_nxt;
            mplier_r     <= mplier_nxt;
            acc_r        <= acc_nxt;
            cnt_r        <= cnt_nxt;
            product      <= product_nxt;
            counter_flag <= flag_nxt;
            busy         <= busy_nxt;
`ifdef SIGNED_MULT_EN
            sign_r       <= sign_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_multiplier_datapath.sv
// Randomized bench for multiplier_datapath (WORD_LENGTH=8) against a cycle-level behavioural model.
module tb_multiplier_datapath;

    localparam int WL = 8;

    logic            clk;
    logic            rst;
    logic            force_reset;
    logic [WL-1:0]   multiplicand;
    logic [WL-1:0]   multiplier;
    logic [2*WL-1:0] product;
    logic            counter_flag;
    logic            busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    multiplier_datapath #(.WORD_LENGTH(WL)) dut (
        .clk          (clk),
        .rst          (rst),
        .force_reset  (force_reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .product      (product),
        .counter_flag (counter_flag),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2*WL-1:0] ref_mul(input logic [WL-1:0] a, input logic [WL-1:0] b);
        int x;
        int y;
`ifdef SIGNED_MULT_EN
        x = int'($signed(a));
        y = int'($signed(b));
`else
        x = int'(a);
        y = int'(b);
`endif
        return (2*WL)'(x * y);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: operands captured on load edges, result due WL run edges later.
    logic [2*WL-1:0] m_prod = '0;
    logic            m_flag = 1'b0;
    logic            m_busy = 1'b0;
    logic            m_done = 1'b0;
    int              m_runs = 0;
    logic [WL-1:0]   m_a    = '0;
    logic [WL-1:0]   m_b    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_prod = '0; m_flag = 1'b0; m_busy = 1'b0; m_done = 1'b0;
            m_runs = 0;  m_a = '0;      m_b = '0;
        end else if (force_reset) begin
            m_a = multiplicand; m_b = multiplier;
            m_runs = 0; m_flag = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        end else if (!m_done) begin
            m_runs++;
            if (m_runs == WL) begin
                m_prod = ref_mul(m_a, m_b);
                m_flag = 1'b1;
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_product", 32'(product), 32'(m_prod));
            check("model_flag", 32'(counter_flag), 32'(m_flag));
            check("model_busy", 32'(busy), 32'(m_busy));
        end
    end

    // Load for 'hold' edges (junk operands except on the last), then run until the flag rises.
    task automatic run_op(input logic [WL-1:0] a, input logic [WL-1:0] b, input int hold,
                          output int lat, output int busy_cyc);
        force_reset  = 1'b1;
        multiplicand = WL'($urandom);
        multiplier   = WL'($urandom);
        repeat (hold - 1) @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        @(negedge clk);
        force_reset = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        while (!counter_flag && lat < 40) begin
            multiplicand = WL'($urandom);
            multiplier   = WL'($urandom);
            @(negedge clk);
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        logic [WL-1:0]   ra;
        logic [WL-1:0]   rb;
        logic [2*WL-1:0] exp_old;

        rst = 1'b1; force_reset = 1'b0; multiplicand = '0; multiplier = '0;
        repeat (2) @(negedge clk);
        check("reset_product", 32'(product), 32'h0);
        check("reset_flag", 32'(counter_flag), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;

        run_op(8'd13, 8'd11, 2, lat, bc);
        check("lat_13x11", 32'(lat), 32'd8);
        check("busy_13x11", 32'(bc), 32'd7);
        check("prod_13x11", 32'(product), 32'd143);

        run_op(8'd255, 8'd255, 1, lat, bc);
`ifdef SIGNED_MULT_EN
        check("prod_ffxff", 32'(product), 32'h0001);
`else
        check("prod_ffxff", 32'(product), 32'hFE01);
`endif
        run_op(8'd0, 8'd200, 1, lat, bc);
        check("prod_0x200", 32'(product), 32'h0);
        check("lat_0x200", 32'(lat), 32'd8);

        run_op(8'hF9, 8'd6, 1, lat, bc);
`ifdef SIGNED_MULT_EN
        check("prod_m7x6", 32'(product), 32'hFFD6);
`else
        check("prod_m7x6", 32'(product), 32'd1494);
`endif
        run_op(8'h80, 8'h80, 1, lat, bc);
        check("prod_m128xm128", 32'(product), 32'd16384);
        run_op(8'h80, 8'd1, 1, lat, bc);
`ifdef SIGNED_MULT_EN
        exp_old = 16'hFF80;
`else
        exp_old = 16'd128;
`endif
        check("prod_m128x1", 32'(product), 32'(exp_old));

        // Abort after four iterations with new operands.
        force_reset = 1'b1; multiplicand = 8'd100; multiplier = 8'd3;
        @(negedge clk);
        force_reset = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_mid_product", 32'(product), 32'(exp_old));
        force_reset = 1'b1; multiplicand = 8'd3; multiplier = 8'd5;
        @(negedge clk);
        check("abort_flag", 32'(counter_flag), 32'h0);
        check("abort_held_product", 32'(product), 32'(exp_old));
        force_reset = 1'b0;
        lat = 0;
        while (!counter_flag && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("abort_lat", 32'(lat), 32'd8);
        check("abort_prod", 32'(product), 32'd15);

        // rst mid-RUN with force_reset low.
        force_reset = 1'b1; multiplicand = 8'd50; multiplier = 8'd2;
        @(negedge clk);
        force_reset = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_run_product", 32'(product), 32'h0);
        check("rst_run_flag", 32'(counter_flag), 32'h0);
        check("rst_run_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // rst in DONE.
        run_op(8'd7, 8'd9, 1, lat, bc);
        check("prod_7x9", 32'(product), 32'd63);
        rst = 1'b1; force_reset = 1'b1;
        @(negedge clk);
        check("rst_done_product", 32'(product), 32'h0);
        check("rst_done_flag", 32'(counter_flag), 32'h0);
        rst = 1'b0; force_reset = 1'b0;
        repeat (2) @(negedge clk);

        // DONE holds while operand inputs toggle.
        run_op(8'd21, 8'd3, 1, lat, bc);
        repeat (20) begin
            multiplicand = WL'($urandom);
            multiplier   = WL'($urandom);
            @(negedge clk);
        end
        check("done_hold_product", 32'(product), 32'd63);
        check("done_hold_flag", 32'(counter_flag), 32'h1);

        for (int i = 0; i < 25; i++) begin
            ra = WL'($urandom);
            rb = WL'($urandom);
            run_op(ra, rb, int'($urandom_range(1, 3)), lat, bc);
            check("rand_lat", 32'(lat), 32'd8);
            check("rand_prod", 32'(product), 32'(ref_mul(ra, rb)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
